// File: rtl/nl_vc_input_unit_pkg.sv
// nl_vc_input_unit_pkg: shared flit, route and VC-state types plus clogb2/oh2bin helpers
package nl_vc_input_unit_pkg;
    localparam int DATA_W = 32;
    localparam int VC_ID_W = 8;
    typedef enum logic [2:0] {LOCAL, NORTH, EAST, SOUTH, WEST} output_port_t;
    typedef logic [1:0] vin_t;
    typedef struct packed {
        logic               valid;
        logic               head;
        logic               tail;
        output_port_t       output_port;
        vin_t               vn;
        logic [VC_ID_W-1:0] vc_id;
    } flit_ctrl_t;
    typedef struct packed {
        flit_ctrl_t         control;
        logic [DATA_W-1:0]  data;
    } flit_t;
    typedef struct packed {
        flit_t        flit;
        output_port_t route;
        vin_t         vn;
    } entry_t;
    typedef struct packed {
        logic empty;
        logic full;
    } fifo_flags_t;
    typedef enum logic [1:0] {IDLE, WAIT_VC, ACTIVE} vc_state_t;
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
    function automatic int oh2bin(input logic [31:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) if (oh[i]) r = r | i;
        return r;
    endfunction
endpackage

// File: rtl/nl_vc_input_unit_if.sv
// nl_vc_input_unit_if: flit, routing, allocation and credit signals of one router input port
interface nl_vc_input_unit_if
    import nl_vc_input_unit_pkg::*;
#(
    parameter int NUM_VCS = 4,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W = clogb2(BUF_DEPTH + 1)
);
    localparam int VW = clogb2(NUM_VCS);
    logic                              push;
    flit_t                             data_in;
    logic [VW-1:0]                     vc_id;
    output_port_t                      route_port_in;
    vin_t                              route_vn_in;
    logic [NUM_VCS-1:0]                pop, select, vc_new_valid;
    logic [NUM_VCS-1:0][NUM_VCS-1:0]   vc_new, allocated_vc;
    flit_t                             data_out;
    logic [NUM_VCS-1:0]                va_req, sa_req, vc_empty, vc_full, credit_out;
    output_port_t [NUM_VCS-1:0]        va_port;
    logic [NUM_VCS-1:0][CNT_W-1:0]     vc_count;
    modport master (
        output push, data_in, vc_id, route_port_in, route_vn_in, pop, select, vc_new, vc_new_valid,
        input  data_out, va_req, va_port, sa_req, allocated_vc, vc_count, vc_empty, vc_full, credit_out
    );
    modport slave (
        input  push, data_in, vc_id, route_port_in, route_vn_in, pop, select, vc_new, vc_new_valid,
        output data_out, va_req, va_port, sa_req, allocated_vc, vc_count, vc_empty, vc_full, credit_out
    );
endinterface

// File: rtl/nl_vc_route_fifo.sv
// nl_vc_route_fifo: single-VC FIFO of {flit, route, vn}; pointers wrap modulo DEPTH, push when full drops
module nl_vc_route_fifo
    import nl_vc_input_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = clogb2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  entry_t           wr_data,
    input  logic             rd_en,
    output entry_t           rd_data,
    output logic [CNT_W-1:0] count,
    output fifo_flags_t      flags
);
    localparam int PW = clogb2(DEPTH);
    entry_t mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic do_wr, do_rd;
    assign flags.empty = count == '0;
    assign flags.full = count == CNT_W'(DEPTH);
    assign do_wr = wr_en && !flags.full;
    assign do_rd = rd_en && !flags.empty;
    assign rd_data = mem[rp];
    // storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clk) if (do_wr) mem[wp] <= wr_data;
    // pointer and occupancy update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_wr) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (do_rd) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end
endmodule

// File: rtl/nl_vc_input_unit.sv
// nl_vc_input_unit: per-VC flit buffers with route-carrying entries and packet FSMs; optional err via NL_VCIU_CHECK_EN
module nl_vc_input_unit
    import nl_vc_input_unit_pkg::*;
#(
    parameter int NUM_VCS = 4,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W = clogb2(BUF_DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    nl_vc_input_unit_if.slave bus
`ifdef NL_VCIU_CHECK_EN
    ,
    output logic err
`endif
);
    localparam int VW = clogb2(NUM_VCS);
    entry_t             front [NUM_VCS];
    output_port_t       route [NUM_VCS];
    vin_t               vn [NUM_VCS];
    logic [NUM_VCS-1:0] alloc [NUM_VCS];
    logic [NUM_VCS-1:0] empty, legal_pop;
    logic [VW-1:0]      sel;
    entry_t             wr_entry;
    flit_t              d;
    assign wr_entry = '{flit: bus.data_in, route: bus.route_port_in, vn: bus.route_vn_in};
    assign sel = VW'(oh2bin(32'(bus.select)));
`ifdef NL_VCIU_CHECK_EN
    logic [NUM_VCS-1:0] bad;
`endif
    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        fifo_flags_t        flags;
        vc_state_t          st;
        output_port_t       rp;
        vin_t               rv;
        logic [NUM_VCS-1:0] av;
        logic               cr;
        nl_vc_route_fifo #(.DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (bus.push && bus.vc_id == VW'(v)),
            .wr_data (wr_entry),
            .rd_en   (legal_pop[v]),
            .rd_data (front[v]),
            .count   (bus.vc_count[v]),
            .flags   (flags)
        );
        assign empty[v] = flags.empty;
        assign legal_pop[v] = bus.pop[v] && st == ACTIVE && !flags.empty;
        assign route[v] = rp;
        assign vn[v] = rv;
        assign alloc[v] = av;
        assign bus.vc_empty[v] = flags.empty;
        assign bus.vc_full[v] = flags.full;
        assign bus.va_req[v] = st == WAIT_VC;
        assign bus.sa_req[v] = st == ACTIVE && !flags.empty;
        assign bus.va_port[v] = rp;
        assign bus.allocated_vc[v] = av;
        assign bus.credit_out[v] = cr;
`ifdef NL_VCIU_CHECK_EN
        assign bad[v] = (bus.pop[v] && (st != ACTIVE || flags.empty))
                     || (bus.vc_new_valid[v] && st != WAIT_VC)
                     || (st == IDLE && !flags.empty && !front[v].flit.control.head)
                     || (bus.push && bus.vc_id == VW'(v) && flags.full);
`endif
        // packet FSM: latch route from the front head, hold the granted VC, credit each departed flit
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st <= IDLE;
                rp <= LOCAL;
                rv <= '0;
                av <= '0;
                cr <= 1'b0;
            end else begin
                cr <= legal_pop[v];
                case (st)
                    IDLE: if (!flags.empty && front[v].flit.control.head) begin
                        st <= WAIT_VC;
                        rp <= front[v].route;
                        rv <= front[v].vn;
                    end
                    WAIT_VC: if (bus.vc_new_valid[v]) begin
                        st <= ACTIVE;
                        av <= bus.vc_new[v];
                    end
                    ACTIVE: if (legal_pop[v] && front[v].flit.control.tail) begin
                        st <= IDLE;
                        av <= '0;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end
    // output mux: front flit of the selected VC with its packet's route, vn and downstream VC
    always_comb begin
        d = front[sel].flit;
        d.control.output_port = route[sel];
        d.control.vn = vn[sel];
        d.control.vc_id = VC_ID_W'(alloc[sel]);
        d.control.valid = d.control.valid & ~empty[sel];
    end
    assign bus.data_out = d;
`ifdef NL_VCIU_CHECK_EN
    // sticky protocol error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (|bad || (bus.pop & (bus.pop - NUM_VCS'(1))) != '0) err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_nl_vc_input_unit.sv
// tb_nl_vc_input_unit: directed scenario tests for nl_vc_input_unit at NUM_VCS=4, BUF_DEPTH=4
module tb_nl_vc_input_unit;
    import nl_vc_input_unit_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
`ifdef NL_VCIU_CHECK_EN
    logic err;
`endif
    nl_vc_input_unit_if #(.NUM_VCS(4), .BUF_DEPTH(4)) bus ();
    nl_vc_input_unit #(.NUM_VCS(4), .BUF_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef NL_VCIU_CHECK_EN
        ,
        .err (err)
`endif
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.push = 1'b0;
        bus.data_in = '0;
        bus.vc_id = '0;
        bus.route_port_in = LOCAL;
        bus.route_vn_in = '0;
        bus.pop = '0;
        bus.select = '0;
        bus.vc_new = '0;
        bus.vc_new_valid = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    task automatic put(input int vc, input logic h, input logic t, input logic [31:0] dat,
                       input output_port_t p, input vin_t n);
        bus.push = 1'b1;
        bus.vc_id = 2'(vc);
        bus.data_in = '0;
        bus.data_in.control.valid = 1'b1;
        bus.data_in.control.head = h;
        bus.data_in.control.tail = t;
        bus.data_in.data = dat;
        bus.route_port_in = p;
        bus.route_vn_in = n;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        tests++; if (bus.vc_empty !== 4'b1111) begin fails++; $display("FAIL rst_empty got=%b exp=1111", bus.vc_empty); end
        tests++; if (bus.vc_full !== 4'b0000) begin fails++; $display("FAIL rst_full got=%b exp=0000", bus.vc_full); end
        tests++; if ({bus.va_req, bus.sa_req, bus.credit_out} !== 12'h000) begin fails++; $display("FAIL rst_req got=%h exp=000", {bus.va_req, bus.sa_req, bus.credit_out}); end
        tests++; if (bus.vc_count !== 12'h000) begin fails++; $display("FAIL rst_count got=%h exp=000", bus.vc_count); end
        tests++; if (bus.allocated_vc !== 16'h0000) begin fails++; $display("FAIL rst_alloc got=%h exp=0000", bus.allocated_vc); end
        tests++; if (bus.data_out.control.valid !== 1'b0) begin fails++; $display("FAIL rst_dvalid got=%b exp=0", bus.data_out.control.valid); end
`ifdef NL_VCIU_CHECK_EN
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", err); end
`endif
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        do_reset();
        tick();
        put(2, 1, 0, 32'hA0, EAST, 2'd1);
        tick();
        put(2, 0, 0, 32'hA1, LOCAL, 2'd0);
        tests++; if (bus.va_req !== 4'b0000) begin fails++; $display("FAIL sp_va_early got=%b exp=0000", bus.va_req); end
        tick();
        tests++; if (bus.va_req !== 4'b0100) begin fails++; $display("FAIL sp_va_req got=%b exp=0100", bus.va_req); end
        tests++; if (bus.va_port[2] !== EAST) begin fails++; $display("FAIL sp_va_port got=%0d exp=%0d", bus.va_port[2], EAST); end
        put(2, 0, 1, 32'hA2, LOCAL, 2'd0);
        tick();
        bus.push = 1'b0;
        bus.vc_new[2] = 4'b0100;
        bus.vc_new_valid = 4'b0100;
        tests++; if (bus.sa_req !== 4'b0000) begin fails++; $display("FAIL sp_sa_early got=%b exp=0000", bus.sa_req); end
        tick();
        bus.vc_new_valid = '0;
        tests++; if (bus.sa_req !== 4'b0100) begin fails++; $display("FAIL sp_sa_req got=%b exp=0100", bus.sa_req); end
        tests++; if (bus.allocated_vc[2] !== 4'b0100) begin fails++; $display("FAIL sp_alloc got=%b exp=0100", bus.allocated_vc[2]); end
        tests++; if (bus.vc_count[2] !== 3'd3) begin fails++; $display("FAIL sp_count got=%0d exp=3", bus.vc_count[2]); end
        for (int i = 0; i < 3; i++) begin
            bus.pop = 4'b0100;
            bus.select = 4'b0100;
            #1;
            tests++; if (bus.data_out.data !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL sp_data%0d got=%h exp=%h", i, bus.data_out.data, 32'hA0 + 32'(i)); end
            tests++; if (bus.data_out.control.vc_id !== 8'h04) begin fails++; $display("FAIL sp_vcid%0d got=%h exp=04", i, bus.data_out.control.vc_id); end
            tests++; if (bus.data_out.control.output_port !== EAST || bus.data_out.control.vn !== 2'd1) begin fails++; $display("FAIL sp_route%0d got=%0d/%0d exp=%0d/1", i, bus.data_out.control.output_port, bus.data_out.control.vn, EAST); end
            tests++; if (bus.data_out.control.tail !== (i == 2)) begin fails++; $display("FAIL sp_tail%0d got=%b exp=%b", i, bus.data_out.control.tail, i == 2); end
            tick();
            tests++; if (bus.credit_out !== 4'b0100) begin fails++; $display("FAIL sp_credit%0d got=%b exp=0100", i, bus.credit_out); end
            tests++; if (bus.vc_count[2] !== 3'(2 - i)) begin fails++; $display("FAIL sp_cnt%0d got=%0d exp=%0d", i, bus.vc_count[2], 2 - i); end
        end
        bus.pop = '0;
        tests++; if (bus.allocated_vc[2] !== 4'b0000 || bus.va_req !== 4'b0000 || bus.sa_req !== 4'b0000) begin fails++; $display("FAIL sp_idle got=%b/%b/%b exp=0000/0000/0000", bus.allocated_vc[2], bus.va_req, bus.sa_req); end
        tests++; if (bus.data_out.control.valid !== 1'b0) begin fails++; $display("FAIL sp_dvalid got=%b exp=0", bus.data_out.control.valid); end
        tick();
        tests++; if (bus.credit_out !== 4'b0000) begin fails++; $display("FAIL sp_credit_end got=%b exp=0000", bus.credit_out); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick();
        put(0, 1, 1, 32'hB0, NORTH, 2'd0);
        tick();
        put(0, 1, 0, 32'hC0, WEST, 2'd2);
        tick();
        bus.push = 1'b0;
        tests++; if (bus.va_req !== 4'b0001 || bus.va_port[0] !== NORTH) begin fails++; $display("FAIL b2b_va_a got=%b/%0d exp=0001/%0d", bus.va_req, bus.va_port[0], NORTH); end
        bus.vc_new[0] = 4'b0001;
        bus.vc_new_valid = 4'b0001;
        tick();
        bus.vc_new_valid = '0;
        bus.pop = 4'b0001;
        bus.select = 4'b0001;
        #1;
        tests++; if (bus.data_out.data !== 32'hB0 || bus.data_out.control.output_port !== NORTH) begin fails++; $display("FAIL b2b_data_a got=%h/%0d exp=b0/%0d", bus.data_out.data, bus.data_out.control.output_port, NORTH); end
        tick();
        bus.pop = '0;
        tests++; if (bus.va_req !== 4'b0000 || bus.credit_out !== 4'b0001 || bus.vc_count[0] !== 3'd1) begin fails++; $display("FAIL b2b_after_tail got=%b/%b/%0d exp=0000/0001/1", bus.va_req, bus.credit_out, bus.vc_count[0]); end
        tick();
        tests++; if (bus.va_req !== 4'b0001) begin fails++; $display("FAIL b2b_va_b got=%b exp=0001", bus.va_req); end
        tests++; if (bus.va_port[0] !== WEST) begin fails++; $display("FAIL b2b_port_b got=%0d exp=%0d", bus.va_port[0], WEST); end
        #1;
        tests++; if (bus.data_out.data !== 32'hC0 || bus.data_out.control.output_port !== WEST || bus.data_out.control.vn !== 2'd2) begin fails++; $display("FAIL b2b_data_b got=%h/%0d/%0d exp=c0/%0d/2", bus.data_out.data, bus.data_out.control.output_port, bus.data_out.control.vn, WEST); end
    endtask

    task automatic test_full();
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            put(1, i == 0, 0, 32'hD0 + 32'(i), SOUTH, 2'd0);
            tick();
        end
        tests++; if (bus.vc_full !== 4'b0010 || bus.vc_count[1] !== 3'd4) begin fails++; $display("FAIL full_flag got=%b/%0d exp=0010/4", bus.vc_full, bus.vc_count[1]); end
        put(1, 0, 1, 32'hDF, SOUTH, 2'd0);
        tick();
        bus.push = 1'b0;
        tests++; if (bus.vc_count[1] !== 3'd4 || bus.vc_full !== 4'b0010) begin fails++; $display("FAIL full_drop got=%0d/%b exp=4/0010", bus.vc_count[1], bus.vc_full); end
`ifdef NL_VCIU_CHECK_EN
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL full_err got=%b exp=1", err); end
`endif
        bus.pop = 4'b0010;
        bus.vc_new[3] = 4'b1000;
        bus.vc_new_valid = 4'b1000;
        tick();
        bus.pop = '0;
        bus.vc_new_valid = '0;
        tests++; if (bus.vc_count[1] !== 3'd4 || bus.credit_out !== 4'b0000) begin fails++; $display("FAIL full_pop_ign got=%0d/%b exp=4/0000", bus.vc_count[1], bus.credit_out); end
        tests++; if (bus.allocated_vc[3] !== 4'b0000 || bus.sa_req !== 4'b0000) begin fails++; $display("FAIL full_vnv_ign got=%b/%b exp=0000/0000", bus.allocated_vc[3], bus.sa_req); end
        bus.vc_new[1] = 4'b0010;
        bus.vc_new_valid = 4'b0010;
        tick();
        bus.vc_new_valid = '0;
        for (int i = 0; i < 4; i++) begin
            bus.pop = 4'b0010;
            bus.select = 4'b0010;
            #1;
            tests++; if (bus.data_out.data !== 32'hD0 + 32'(i)) begin fails++; $display("FAIL full_data%0d got=%h exp=%h", i, bus.data_out.data, 32'hD0 + 32'(i)); end
            tick();
        end
        bus.pop = '0;
        tests++; if (bus.vc_count[1] !== 3'd0 || bus.vc_empty !== 4'b1111) begin fails++; $display("FAIL full_drain got=%0d/%b exp=0/1111", bus.vc_count[1], bus.vc_empty); end
    endtask

    task automatic test_push_pop();
        do_reset();
        tick();
        put(3, 1, 0, 32'hE0, EAST, 2'd3);
        tick();
        put(3, 0, 0, 32'hE1, LOCAL, 2'd0);
        tick();
        bus.push = 1'b0;
        bus.vc_new[3] = 4'b1000;
        bus.vc_new_valid = 4'b1000;
        tick();
        bus.vc_new_valid = '0;
        tests++; if (bus.vc_count[3] !== 3'd2 || bus.sa_req !== 4'b1000) begin fails++; $display("FAIL pp_pre got=%0d/%b exp=2/1000", bus.vc_count[3], bus.sa_req); end
        put(3, 0, 1, 32'hE2, LOCAL, 2'd0);
        bus.pop = 4'b1000;
        bus.select = 4'b1000;
        tick();
        bus.push = 1'b0;
        bus.pop = '0;
        tests++; if (bus.vc_count[3] !== 3'd2 || bus.credit_out !== 4'b1000) begin fails++; $display("FAIL pp_same got=%0d/%b exp=2/1000", bus.vc_count[3], bus.credit_out); end
        tick();
        tests++; if (bus.credit_out !== 4'b0000 || bus.vc_count[3] !== 3'd2) begin fails++; $display("FAIL pp_once got=%b/%0d exp=0000/2", bus.credit_out, bus.vc_count[3]); end
        tests++; if (bus.data_out.data !== 32'hE1) begin fails++; $display("FAIL pp_front got=%h exp=e1", bus.data_out.data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        put(0, 1, 0, 32'hF0, NORTH, 2'd0);
        tick();
        put(0, 0, 0, 32'hF1, LOCAL, 2'd0);
        tick();
        put(0, 0, 1, 32'hF2, LOCAL, 2'd0);
        bus.vc_new[0] = 4'b0001;
        bus.vc_new_valid = 4'b0001;
        tick();
        bus.push = 1'b0;
        bus.vc_new_valid = '0;
        bus.pop = 4'b0001;
        tick();
        bus.pop = '0;
        tick();
        tests++; if (bus.sa_req !== 4'b0001 || bus.vc_count[0] !== 3'd2) begin fails++; $display("FAIL ar_pre got=%b/%0d exp=0001/2", bus.sa_req, bus.vc_count[0]); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.sa_req !== 4'b0000 || bus.va_req !== 4'b0000 || bus.allocated_vc[0] !== 4'b0000) begin fails++; $display("FAIL ar_idle got=%b/%b/%b exp=0000/0000/0000", bus.sa_req, bus.va_req, bus.allocated_vc[0]); end
        tests++; if (bus.vc_count[0] !== 3'd0 || bus.vc_empty !== 4'b1111) begin fails++; $display("FAIL ar_flush got=%0d/%b exp=0/1111", bus.vc_count[0], bus.vc_empty); end
        rst = 1'b0;
        tick();
        tests++; if (bus.credit_out !== 4'b0000) begin fails++; $display("FAIL ar_credit got=%b exp=0000", bus.credit_out); end
        tick();
        tests++; if (bus.credit_out !== 4'b0000 || bus.va_req !== 4'b0000) begin fails++; $display("FAIL ar_quiet got=%b/%b exp=0000/0000", bus.credit_out, bus.va_req); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_full();
        test_push_pop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
